// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Shares one combinational 32-bit ALU between two requesters. A round-robin
//   arbiter accepts one op at a time, registers its operands and op select
//   into the ALU, waits an op-dependent number of cycles (longer for the booth
//   multiplier) and then returns the captured result as a one-cycle tagged
//   response.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   reqN_valid/ready         per-requester handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_sel per-requester operands and op code
//   alu_a, alu_b, alu_sel    registered operands / op select to the ALU
//   alu_out, alu_zero        ALU result and zero flag
//   rsp_valid                one-cycle pulse, response fields valid
//   rsp_id, rsp_data,
//   rsp_zero                 owner of the response, captured result and flag
//   busy                     high while an op is in flight (EXEC or RESP)
//
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high. Requesters keep valid and payload stable until
// they see ready; dropping valid earlier withdraws the request with no side
// effect. ready is combinational and only ever asserted in IDLE, for the
// granted requester, and never while rst is high.
//
// Parameters ALU_LAT and MUL_LAT must both be at least 1.

module alu_share_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_sel,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic        busy
);

    localparam logic [3:0] SEL_MUL = 4'b0100;
    localparam int MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
    // cnt only ever holds LAT-1, so $clog2(MAX_LAT) bits are enough.
    localparam int CW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] CNT_MUL = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] CNT_ALU = CW'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic            rr_last;
    logic [CW-1:0]   cnt;

    logic            grant0;
    logic            grant1;
    logic            accept;
    logic [31:0]     g_a;
    logic [31:0]     g_b;
    logic [3:0]      g_sel;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || rr_last);
        grant1 = req1_valid && (!req0_valid || !rr_last);
        g_a    = grant1 ? req1_a   : req0_a;
        g_b    = grant1 ? req1_b   : req0_b;
        g_sel  = grant1 ? req1_sel : req0_sel;
    end

    // Gating with rst keeps a reset cycle free of both acceptance and
    // response pulses, whatever state the FSM is in.
    assign req0_ready = !rst && (state == IDLE) && grant0;
    assign req1_ready = !rst && (state == IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;
    assign rsp_valid  = !rst && (state == RESP);
    assign busy       = !rst && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_last  <= 1'b1;
            cnt      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a   <= g_a;
                        alu_b   <= g_b;
                        alu_sel <= g_sel;
                        rsp_id  <= grant1;
                        rr_last <= grant1;
                        // Undefined op codes are forwarded as-is and take the
                        // short latency.
                        cnt     <= (g_sel == SEL_MUL) ? CNT_MUL : CNT_ALU;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_data <= alu_out;
                        rsp_zero <= alu_zero;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
